fetch_queue: RTL and testbench

Instruction fetch unit with a prefetch buffer, placed upstream of the IF/ID pipeline register. It owns the fetch PC and requests words from instruction memory over a req/ack handshake. Fetched instructions and their PC+4 values go into a small circular FIFO, which decode drains with a valid/ready handshake. A branch/jump redirect from the MEM stage flushes the queue and restarts fetch at the target.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/fetch_queue_if.sv | 25 ++
 rtl/fetch_queue_fifo.sv | 69 ++++++
 rtl/fetch_queue.sv | 74 +++++++
 tb/tb_fetch_queue.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch queue entry type.
package cpu_pkg;
  localparam int          WORD_W           = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc4;
  } fq_entry_t;

  // Sequential PC; wraps modulo 2^32 by construction.
  function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] pc);
    return pc + PC_STEP;
  endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction-memory request side and decode-facing side.
interface fetch_queue_if;
  import cpu_pkg::*;

  // im_req/im_ack: a word transfers in a cycle where both are high; ack alone is ignored.
  // valid/ready: the head entry transfers in a cycle where both are high; valid never waits on ready.
  logic              im_req;
  logic [WORD_W-1:0] im_addr;
  logic              im_ack;
  logic [WORD_W-1:0] im_data;
  logic              valid;
  logic              ready;
  logic [WORD_W-1:0] instr;
  logic [WORD_W-1:0] pc4;

  modport master (
    output im_req, im_addr, valid, instr, pc4,
    input  im_ack, im_data, ready
  );

  modport slave (
    input  im_req, im_addr, valid, instr, pc4,
    output im_ack, im_data, ready
  );
endinterface

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo: circular buffer of {instr, pc4} entries with flush; DEPTH is a power of two.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fq_entry_t              wdata,
  output fq_entry_t              rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fq_entry_t         entries_q [DEPTH];
  logic [AW-1:0]     wp_q, wp_d;
  logic [AW-1:0]     rp_q, rp_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign rdata   = entries_q[rp_q];
  assign count   = count_q;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push_ok) wp_d = wp_q + AW'(1);
      if (pop_ok)  rp_d = rp_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is read from a slot before it is written.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) entries_q[wp_q] <= wdata;
  end
endmodule

// File: rtl/fetch_queue.sv
// Fetch unit: owns the fetch PC, requests words from instruction memory and queues them for decode.
// Optional FETCH_QUEUE_BYPASS_EN: an acked word reaches decode in the same cycle when the queue is empty.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   redirect,
  input  logic [WORD_W-1:0]      redirect_pc,
  fetch_queue_if.master          bus,
  output logic [$clog2(DEPTH):0] count
);
  logic [WORD_W-1:0] fpc_q, fpc_d;
  logic              fifo_full, fifo_empty;
  logic              push_ack, bypass, fifo_push, fifo_pop, pop_fire;
  fq_entry_t         wdata, rdata;

  // The request never looks at ready, so decode stays off the memory path.
  assign bus.im_req  = !clr && !redirect && !fifo_full;
  assign bus.im_addr = fpc_q;
  assign push_ack    = bus.im_req && bus.im_ack;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = push_ack && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign bus.valid = !fifo_empty || bypass;
  assign pop_fire  = bus.valid && bus.ready;
  assign fifo_pop  = pop_fire && !fifo_empty;
  // A bypassed word that decode takes immediately is never stored.
  assign fifo_push = push_ack && !(bypass && bus.ready);
  assign wdata     = '{instr: bus.im_data, pc4: next_pc(fpc_q)};

  always_comb begin
    bus.instr = NOP_INSTR;
    bus.pc4   = '0;
    if (!fifo_empty) begin
      bus.instr = rdata.instr;
      bus.pc4   = rdata.pc4;
    end else if (bypass) begin
      bus.instr = bus.im_data;
      bus.pc4   = next_pc(fpc_q);
    end
  end

  always_comb begin
    fpc_d = fpc_q;
    if (redirect)      fpc_d = redirect_pc;
    else if (push_ack) fpc_d = next_pc(fpc_q);
  end

  always_ff @(posedge clk) begin
    if (clr) fpc_q <= RESET_PC;
    else     fpc_q <= fpc_d;
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .wdata (wdata),
    .rdata (rdata),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: random and directed fetch traffic against a queue-level reference model.
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam int          DEPTH  = 4;
  localparam int          CW     = $clog2(DEPTH) + 1;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic [CW-1:0] count;

  fetch_queue_if fq_if ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .clr         (clr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (fq_if.master),
    .count       (count)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign fq_if.im_data = mem_word(fq_if.im_addr);

  // Reference model: fetch PC plus the ordered list of words decode should see.
  logic [63:0] exp_q[$];
  logic [31:0] m_fpc = RST_PC;
  logic        m_exp_valid = 1'b0;
  logic        p_clr = 1'b1, p_redir = 1'b0, p_push = 1'b0;
  logic [31:0] p_rpc = '0;
  bit          started = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: one clock cycle of stimulus; the model advances at the edge that commits last cycle.
  task automatic step(input logic ack, input logic rdy, input logic redir,
                      input logic [31:0] rpc, input logic rst);
    int  pre_occ;
    logic m_req;
    @(posedge clk);
    if (p_clr) begin
      exp_q.delete();
      m_fpc = RST_PC;
    end else if (p_redir) begin
      exp_q.delete();
      m_fpc = p_rpc;
    end else if (p_push) begin
      m_fpc = m_fpc + 32'd4;
    end
    #1;
    clr          = rst;
    redirect     = redir;
    redirect_pc  = rpc;
    fq_if.im_ack = ack;
    fq_if.ready  = rdy;
    #1;
    pre_occ = exp_q.size();
    m_req   = !rst && !redir && (pre_occ < DEPTH);
    chk("count", 64'(count), 64'(pre_occ));
    chk("im_addr", 64'(fq_if.im_addr), 64'(m_fpc));
    chk("im_req", 64'(fq_if.im_req), 64'(m_req));
    p_push = m_req && ack;
    if (p_push) exp_q.push_back({mem_word(m_fpc), m_fpc + 32'd4});
    m_exp_valid = (pre_occ > 0) || (BYPASS && p_push);
    p_clr   = rst;
    p_redir = redir;
    p_rpc   = rpc;
    started = 1'b1;
  endtask

  // Monitor: pops the expected queue whenever decode takes an entry.
  always @(negedge clk) begin
    if (started) begin
      chk("valid", 64'(fq_if.valid), 64'(m_exp_valid));
      if (fq_if.valid && fq_if.ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_order: got instr %h pc4 %h expected no entry at %0t",
                   fq_if.instr, fq_if.pc4, $time);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("instr", 64'(fq_if.instr), 64'(e[63:32]));
          chk("pc4", 64'(fq_if.pc4), 64'(e[31:0]));
        end
      end else if (!fq_if.valid) begin
        chk("instr_idle", 64'(fq_if.instr), 64'h0);
        chk("pc4_idle", 64'(fq_if.pc4), 64'h0);
      end
    end
  end

  initial begin
    fq_if.im_ack = 1'b0;
    fq_if.ready  = 1'b0;

    // Reset held two cycles, then streaming with single-cycle acks.
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    // Backpressure until full, then release.
    repeat (7) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    // Slow memory: ack every third cycle.
    for (int i = 0; i < 12; i++) step(i % 3 == 2, 1'b1, 1'b0, 32'h0, 1'b0);

    // Drain, fill to three, then redirect with a same-cycle ack.
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 32'h0000_0040, 1'b0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    // Fetch PC wrap through 2^32.
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
    repeat (2 * DEPTH) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    // Empty queue with an ack and ready high (same-cycle delivery when bypass is built in).
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    // Random traffic with occasional redirects and resets.
    repeat (500) begin
      logic [31:0] tgt;
      tgt = $urandom();
      tgt[1:0] = 2'b00;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 15) == 0), tgt, 1'($urandom_range(0, 60) == 0));
    end

    repeat (DEPTH + 2) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
